imem_fetch: RTL and testbench

//   Instruction fetch unit: the requesting end of the imem interface. Owns the PC,

---
 rtl/imem_fetch.sv | 92 +++++++++
 tb/tb_imem_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction fetch unit: owns the PC, addresses the instruction ROM and
// registers the returned word into a one-entry buffer for decode.
// Optional: FETCH_PREDECODE_JUMP_EN follows j words at fetch time.
module imem_fetch #(
    parameter int                  ADDR_W   = 6,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt_req,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    // state | meaning
    // IDLE  | one cycle after reset, no fetch
    // RUN   | fetching whenever the buffer is free or being drained
    // HALT  | fetch stopped, buffer drains; left only by redirect
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              advance;

    assign imem_addr = pc;
    assign advance   = (state == RUN) && !halt_req && (!out_valid || out_ready);

`ifdef FETCH_PREDECODE_JUMP_EN
    // A j word is still delivered, but fetch follows its target directly.
    assign pc_next_seq = (imem_data[31:26] == 6'h02) ? imem_data[ADDR_W-1:0]
                                                     : pc + ADDR_W'(1);
`else
    assign pc_next_seq = pc + ADDR_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN, HALT: begin
                    if (redirect_valid) begin
                        pc        <= redirect_addr;
                        out_valid <= 1'b0;
                        state     <= RUN;
                        halted    <= 1'b0;
                    end else if (advance) begin
                        out_instr   <= imem_data;
                        out_pc      <= pc;
                        out_valid   <= 1'b1;
                        pc          <= pc_next_seq;
                        fetch_count <= fetch_count + CNT_W'(1);
                    end else begin
                        if (out_valid && out_ready)
                            out_valid <= 1'b0;
                        if (state == RUN && halt_req) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: a table of per-cycle inputs and expected
// outputs, plus hand-written reset and startup sequences.
module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
    logic        redirect_valid;
    logic [5:0]  redirect_addr;
    logic        halt_req;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] rom [64];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    imem_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [5:0]  ra;
        logic        hr;
        logic        ev;
        logic [5:0]  epc;
        logic [5:0]  ea;
        logic        eh;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdy, input logic rv, input logic [5:0] ra,
                       input logic hr, input logic ev, input logic [5:0] epc,
                       input logic [5:0] ea, input logic eh, input logic [15:0] ecnt);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.ra = ra; v.hr = hr;
        v.ev = ev; v.epc = epc; v.ea = ea; v.eh = eh; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input int idx, input vec_t v);
        string s;
        s = $sformatf("step%0d", idx);
        check({s, " out_valid"}, 32'(out_valid), 32'(v.ev));
        check({s, " imem_addr"}, 32'(imem_addr), 32'(v.ea));
        check({s, " halted"}, 32'(halted), 32'(v.eh));
        check({s, " fetch_count"}, 32'(fetch_count), 32'(v.ecnt));
        if (v.ev) begin
            check({s, " out_pc"}, 32'(out_pc), 32'(v.epc));
            check({s, " out_instr"}, out_instr, rom[v.epc]);
        end
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 64; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[0]  = 32'h2002_0005;
        rom[1]  = 32'h2007_0003;
        rom[2]  = 32'h2003_000c;
        rom[13] = 32'h0800_000f;

        //  rdy rv ra  hr  ev epc ea eh cnt
        add(1, 0, 0,  0,  0, 0,  0, 0, 0);    // IDLE -> RUN, no fetch
        add(1, 0, 0,  0,  1, 0,  1, 0, 1);
        add(1, 0, 0,  0,  1, 1,  2, 0, 2);
        add(1, 0, 0,  0,  1, 2,  3, 0, 3);
        add(1, 0, 0,  0,  1, 3,  4, 0, 4);
        add(1, 0, 0,  0,  1, 4,  5, 0, 5);
        add(0, 0, 0,  0,  1, 4,  5, 0, 5);    // backpressure x3
        add(0, 0, 0,  0,  1, 4,  5, 0, 5);
        add(0, 0, 0,  0,  1, 4,  5, 0, 5);
        add(1, 0, 0,  0,  1, 5,  6, 0, 6);
        add(1, 1, 14, 0,  0, 0, 14, 0, 6);    // redirect flushes pc 6
        add(1, 0, 0,  0,  1, 14, 15, 0, 7);
        add(1, 1, 62, 0,  0, 0, 62, 0, 7);
        add(1, 0, 0,  0,  1, 62, 63, 0, 8);
        add(1, 0, 0,  0,  1, 63, 0,  0, 9);   // wrap
        add(1, 0, 0,  0,  1, 0,  1,  0, 10);
        add(1, 1, 6,  0,  0, 0,  6,  0, 10);
        add(1, 0, 0,  0,  1, 6,  7,  0, 11);
        add(1, 0, 0,  0,  1, 7,  8,  0, 12);
        add(0, 0, 0,  1,  1, 7,  8,  1, 12);  // halt at pc 8, entry 7 held
        add(0, 0, 0,  0,  1, 7,  8,  1, 12);
        add(1, 0, 0,  0,  0, 0,  8,  1, 12);  // drained
        add(1, 0, 0,  0,  0, 0,  8,  1, 12);
        add(1, 1, 0,  0,  0, 0,  0,  0, 12);  // redirect leaves HALT
        add(1, 0, 0,  0,  1, 0,  1,  0, 13);
        add(1, 1, 12, 0,  0, 0, 12,  0, 13);
        add(1, 0, 0,  0,  1, 12, 13, 0, 14);
`ifdef FETCH_PREDECODE_JUMP_EN
        add(1, 0, 0,  0,  1, 13, 15, 0, 15);
        add(1, 0, 0,  0,  1, 15, 16, 0, 16);
`else
        add(1, 0, 0,  0,  1, 13, 14, 0, 15);
        add(1, 0, 0,  0,  1, 14, 15, 0, 16);
`endif
        add(1, 1, 20, 1,  0, 0, 20,  0, 16);  // halt + redirect: redirect wins
        add(1, 0, 0,  0,  1, 20, 21, 0, 17);

        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_addr = '0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset imem_addr", 32'(imem_addr), 32'd0);
        check("reset out_instr", out_instr, 32'd0);
        check("reset out_pc", 32'(out_pc), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset fetch_count", 32'(fetch_count), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_addr  = vecs[i].ra;
            halt_req       = vecs[i].hr;
            @(posedge clk);
            #1;
            check_all(i, vecs[i]);
            @(negedge clk);
        end

        // Reset mid-stream discards a valid buffer on the same edge.
        out_ready = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_instr", out_instr, 32'd0);
        check("midrst imem_addr", 32'(imem_addr), 32'd0);
        check("midrst fetch_count", 32'(fetch_count), 32'd0);

        // Bounded wait for the first valid after reset: expected on cycle 2.
        @(negedge clk);
        rst = 1'b0;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!out_valid && waited < 8);
        check("startup latency", 32'(waited), 32'd2);
        check("startup out_pc", 32'(out_pc), 32'd0);
        check("startup out_instr", out_instr, 32'h2002_0005);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
